// File: rtl/peripheral_msi_slave_port_axi4_if.sv
// rtl/peripheral_msi_slave_port_axi4_if.sv - multi-master to single-slave AHB-style port bundle
interface peripheral_msi_slave_port_axi4_if #(
    parameter int PLEN    = 64,
    parameter int XLEN    = 64,
    parameter int MASTERS = 5
);
    logic [MASTERS-1:0][2:0]      mstpriority;
    logic [MASTERS-1:0]           mstHSEL;
    logic [MASTERS-1:0][PLEN-1:0] mstHADDR;
    logic [MASTERS-1:0][XLEN-1:0] mstHWDATA;
    logic [MASTERS-1:0]           mstHWRITE;
    logic [MASTERS-1:0]           mstHMASTLOCK;
    logic [MASTERS-1:0][2:0]      mstHSIZE;
    logic [MASTERS-1:0][2:0]      mstHBURST;
    logic [MASTERS-1:0][3:0]      mstHPROT;
    logic [MASTERS-1:0][1:0]      mstHTRANS;
    logic [MASTERS-1:0]           mstHREADY;
    logic [MASTERS-1:0]           can_switch;
    logic [XLEN-1:0]              mstHRDATA;
    logic                         mstHREADYOUT;
    logic                         mstHRESP;
    logic [MASTERS-1:0]           master_granted;
    logic                         slv_HSEL;
    logic [PLEN-1:0]              slv_HADDR;
    logic [XLEN-1:0]              slv_HWDATA;
    logic                         slv_HWRITE;
    logic                         slv_HMASTLOCK;
    logic [2:0]                   slv_HSIZE;
    logic [2:0]                   slv_HBURST;
    logic [3:0]                   slv_HPROT;
    logic [1:0]                   slv_HTRANS;
    logic                         slv_HREADY;
    logic [XLEN-1:0]              slv_HRDATA;
    logic                         slv_HREADYOUT;
    logic                         slv_HRESP;

    modport slave (
        input  mstpriority, mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHMASTLOCK,
               mstHSIZE, mstHBURST, mstHPROT, mstHTRANS, mstHREADY, can_switch,
               slv_HRDATA, slv_HREADYOUT, slv_HRESP,
        output mstHRDATA, mstHREADYOUT, mstHRESP, master_granted,
               slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HMASTLOCK,
               slv_HSIZE, slv_HBURST, slv_HPROT, slv_HTRANS, slv_HREADY
    );

    modport master (
        output mstpriority, mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHMASTLOCK,
               mstHSIZE, mstHBURST, mstHPROT, mstHTRANS, mstHREADY, can_switch,
               slv_HRDATA, slv_HREADYOUT, slv_HRESP,
        input  mstHRDATA, mstHREADYOUT, mstHRESP, master_granted,
               slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HMASTLOCK,
               slv_HSIZE, slv_HBURST, slv_HPROT, slv_HTRANS, slv_HREADY
    );
endinterface

// File: rtl/peripheral_msi_slave_port_axi4.sv
// rtl/peripheral_msi_slave_port_axi4.sv - priority/round-robin arbiter muxing masters onto one slave
module peripheral_msi_slave_port_axi4 #(
    parameter int PLEN    = 64,
    parameter int XLEN    = 64,
    parameter int MASTERS = 5
) (
    input logic HCLK,
    input logic HRESETn,
    peripheral_msi_slave_port_axi4_if.slave bus
);
    localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0] grant_q;
    logic [MASTERS-1:0] dp_owner;
    logic [IDX_W-1:0]   rr_last;
    logic [IDX_W-1:0]   g_idx;
    logic               switch_ok;
    logic [2:0]         max_prio;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [MASTERS-1:0] win_onehot;
    logic [IDX_W:0]     rr_sum;
    logic [IDX_W-1:0]   rr_idx;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < MASTERS; i++)
            if (grant_q[i]) g_idx = i[IDX_W-1:0];
    end

    assign switch_ok = bus.slv_HREADYOUT & ((grant_q == '0) | bus.can_switch[g_idx]);

    // Highest priority first, then scan upward from the last winner so ties rotate.
    always_comb begin
        max_prio  = '0;
        win_idx   = '0;
        win_found = 1'b0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int i = 0; i < MASTERS; i++)
            if (bus.mstHSEL[i] && (bus.mstpriority[i] > max_prio)) max_prio = bus.mstpriority[i];
        for (int k = 1; k <= MASTERS; k++) begin
            rr_sum = {1'b0, rr_last} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(MASTERS)) rr_sum = rr_sum - (IDX_W+1)'(MASTERS);
            rr_idx = rr_sum[IDX_W-1:0];
            if (!win_found && bus.mstHSEL[rr_idx] && (bus.mstpriority[rr_idx] == max_prio)) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    assign win_onehot = win_found ? (MASTERS'(1) << win_idx) : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q  <= '0;
            dp_owner <= '0;
            rr_last  <= IDX_W'(MASTERS - 1);
        end else begin
            if (switch_ok) begin
                grant_q <= win_onehot;
                if (win_found) rr_last <= win_idx;
            end
            if (bus.slv_HREADYOUT) dp_owner <= grant_q;
        end
    end

    assign bus.master_granted = grant_q;

    always_comb begin
        bus.slv_HSEL      = 1'b0;
        bus.slv_HADDR     = '0;
        bus.slv_HWRITE    = 1'b0;
        bus.slv_HMASTLOCK = 1'b0;
        bus.slv_HSIZE     = '0;
        bus.slv_HBURST    = '0;
        bus.slv_HPROT     = '0;
        bus.slv_HTRANS    = 2'b00;
        for (int i = 0; i < MASTERS; i++) begin
            if (grant_q[i]) begin
                bus.slv_HSEL      = bus.mstHSEL[i];
                bus.slv_HADDR     = bus.mstHADDR[i];
                bus.slv_HWRITE    = bus.mstHWRITE[i];
                bus.slv_HMASTLOCK = bus.mstHMASTLOCK[i];
                bus.slv_HSIZE     = bus.mstHSIZE[i];
                bus.slv_HBURST    = bus.mstHBURST[i];
                bus.slv_HPROT     = bus.mstHPROT[i];
                bus.slv_HTRANS    = bus.mstHTRANS[i];
            end
        end
    end

    // Data phase follows the previous address-phase owner, not the current grant.
    always_comb begin
        bus.slv_HWDATA = '0;
        bus.slv_HREADY = 1'b1;
        for (int i = 0; i < MASTERS; i++) begin
            if (dp_owner[i]) begin
                bus.slv_HWDATA = bus.mstHWDATA[i];
                bus.slv_HREADY = bus.mstHREADY[i];
            end
        end
    end

    assign bus.mstHRDATA    = bus.slv_HRDATA;
    assign bus.mstHREADYOUT = bus.slv_HREADYOUT;
    assign bus.mstHRESP     = bus.slv_HRESP;
endmodule

// File: tb/tb_peripheral_msi_slave_port_axi4.sv
// tb/tb_peripheral_msi_slave_port_axi4.sv - directed scoreboard bench for the slave port arbiter
module tb_peripheral_msi_slave_port_axi4;
    localparam int PLEN    = 64;
    localparam int XLEN    = 64;
    localparam int MASTERS = 5;

    logic HCLK;
    logic HRESETn;
    int   total;
    int   bad;
    logic [MASTERS-1:0] exp_q[$];
    logic [MASTERS-1:0] rr_seq[5];

    peripheral_msi_slave_port_axi4_if #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(MASTERS)) bus ();

    peripheral_msi_slave_port_axi4 #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(MASTERS)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag);
        logic [MASTERS-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, bus.master_granted);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 64'(bus.master_granted), 64'(e));
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rr_seq[0] = 5'b00010; rr_seq[1] = 5'b00100; rr_seq[2] = 5'b10000;
        rr_seq[3] = 5'b00010; rr_seq[4] = 5'b00100;

        HRESETn           = 1'b0;
        bus.mstpriority   = '0;
        bus.mstHSEL       = '0;
        bus.mstHADDR      = '0;
        bus.mstHWDATA     = '0;
        bus.mstHWRITE     = '0;
        bus.mstHMASTLOCK  = '0;
        bus.mstHSIZE      = '0;
        bus.mstHBURST     = '0;
        bus.mstHPROT      = '0;
        bus.mstHTRANS     = '0;
        bus.mstHREADY     = '1;
        bus.can_switch    = '0;
        bus.slv_HRDATA    = 64'h1234_5678_9abc_def0;
        bus.slv_HREADYOUT = 1'b1;
        bus.slv_HRESP     = 1'b1;
        #12;
        chk("rst_grant", 64'(bus.master_granted), 64'h0);
        chk("rst_hsel", 64'(bus.slv_HSEL), 64'h0);
        chk("rst_htrans", 64'(bus.slv_HTRANS), 64'h0);
        chk("rst_hready", 64'(bus.slv_HREADY), 64'h1);
        chk("pass_hrdata", 64'(bus.mstHRDATA), 64'h1234_5678_9abc_def0);
        chk("pass_hresp", 64'(bus.mstHRESP), 64'h1);
        chk("pass_hreadyout", 64'(bus.mstHREADYOUT), 64'h1);
        bus.slv_HRESP = 1'b0;
        step();
        HRESETn = 1'b1;
        step();

        // single request from master 2
        bus.mstHSEL[2]   = 1'b1;
        bus.mstHTRANS[2] = 2'b10;
        bus.mstHADDR[2]  = 64'h100;
        bus.mstHWRITE[2] = 1'b1;
        bus.mstHWDATA[2] = 64'haaaa;
        exp_q.push_back(5'b00100);
        step();
        chk_grant("single_grant");
        chk("single_haddr", 64'(bus.slv_HADDR), 64'h100);
        chk("single_hsel", 64'(bus.slv_HSEL), 64'h1);
        chk("single_htrans", 64'(bus.slv_HTRANS), 64'h2);
        chk("single_hwdata_pre", 64'(bus.slv_HWDATA), 64'h0);
        exp_q.push_back(5'b00100);
        step();
        chk_grant("single_hold");
        chk("single_dp_hwdata", 64'(bus.slv_HWDATA), 64'haaaa);
        bus.mstHSEL    = '0;
        bus.can_switch = '1;
        exp_q.push_back(5'b00000);
        step();
        chk_grant("single_release");
        chk("idle_htrans", 64'(bus.slv_HTRANS), 64'h0);
        chk("idle_haddr", 64'(bus.slv_HADDR), 64'h0);

        // priority: 3 (prio 5) beats 0 (prio 1); no preemption until master 3 lets go
        bus.can_switch     = '0;
        bus.mstpriority[0] = 3'd1;
        bus.mstpriority[3] = 3'd5;
        bus.mstHSEL[0]     = 1'b1;
        bus.mstHSEL[3]     = 1'b1;
        exp_q.push_back(5'b01000);
        step();
        chk_grant("prio_win");
        exp_q.push_back(5'b01000);
        step();
        chk_grant("prio_hold_noswitch");
        bus.mstHSEL[3]    = 1'b0;
        bus.slv_HREADYOUT = 1'b0;
        exp_q.push_back(5'b01000);
        step();
        chk_grant("prio_hold_nolock_ready0");
        bus.can_switch[3] = 1'b1;
        exp_q.push_back(5'b01000);
        step();
        chk_grant("prio_hold_ready0");
        bus.slv_HREADYOUT = 1'b1;
        exp_q.push_back(5'b00001);
        step();
        chk_grant("prio_low_after_switch");
        bus.mstHSEL    = '0;
        bus.can_switch = '1;
        exp_q.push_back(5'b00000);
        step();
        chk_grant("prio_idle");

        // round robin among equal priorities 1,2,4 (last winner was 0)
        bus.mstpriority    = '0;
        bus.mstpriority[1] = 3'd3;
        bus.mstpriority[2] = 3'd3;
        bus.mstpriority[4] = 3'd3;
        bus.mstHSEL        = 5'b10110;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(rr_seq[i]);
            step();
            chk_grant($sformatf("rr_%0d", i));
        end

        // wait states block a higher-priority switch
        bus.mstHSEL      = 5'b00100;
        bus.mstHWDATA[2] = 64'h2222;
        bus.mstHWDATA[4] = 64'h4444;
        exp_q.push_back(5'b00100);
        step();
        chk_grant("ws_sole_regrant");
        bus.slv_HREADYOUT  = 1'b0;
        bus.mstpriority[4] = 3'd7;
        bus.mstHSEL        = 5'b10100;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(5'b00100);
            step();
            chk_grant($sformatf("ws_hold_%0d", i));
            chk($sformatf("ws_dp_%0d", i), 64'(bus.slv_HWDATA), 64'h2222);
        end
        bus.slv_HREADYOUT = 1'b1;
        exp_q.push_back(5'b10000);
        step();
        chk_grant("ws_switch");
        chk("ws_dp_old", 64'(bus.slv_HWDATA), 64'h2222);
        exp_q.push_back(5'b10000);
        step();
        chk_grant("ws_keep");
        chk("ws_dp_new", 64'(bus.slv_HWDATA), 64'h4444);

        // locked INCR4 on master 4 while master 1 (prio 6) waits
        bus.mstpriority[4] = 3'd2;
        bus.mstpriority[1] = 3'd6;
        bus.mstHSEL        = 5'b10110;
        bus.can_switch[4]  = 1'b0;
        bus.mstHBURST[4]   = 3'b011;
        bus.mstHMASTLOCK[4] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bus.mstHWDATA[4] = 64'h4000 + 64'(b);
            if (b == 3) bus.can_switch[4] = 1'b1;
            exp_q.push_back(b == 3 ? 5'b00010 : 5'b10000);
            step();
            chk_grant($sformatf("lock_beat_%0d", b));
            chk($sformatf("lock_dp_%0d", b), 64'(bus.slv_HWDATA), 64'h4000 + 64'(b));
        end
        chk("lock_burst_after", 64'(bus.slv_HBURST), 64'h0);

        // asynchronous reset mid-transfer
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_grant", 64'(bus.master_granted), 64'h0);
        chk("arst_hsel", 64'(bus.slv_HSEL), 64'h0);
        chk("arst_hready", 64'(bus.slv_HREADY), 64'h1);
        chk("arst_htrans", 64'(bus.slv_HTRANS), 64'h0);
        step();
        HRESETn = 1'b1;
        exp_q.push_back(5'b00010);
        step();
        chk_grant("post_rst_grant");
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/peripheral_msi_slave_port_axi4.md
PERIPHERAL_MSI_SLAVE_PORT_AXI4 -- requirements
Module: peripheral_msi_slave_port_axi4

Interface
REQ-001 SHALL have parameters: PLEN, default 64, address width; XLEN, default 64, data width; MASTERS, default 5, number of master ports arbitrated.
REQ-002 SHALL have ports (clock and reset first):
- HCLK  in  1  clock; one clock, all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- mstpriority  in  MASTERS x 3  per-master priority, higher wins
- mstHSEL  in  MASTERS  per-master request/select
- mstHADDR  in  MASTERS x PLEN  per-master address
- mstHWDATA  in  MASTERS x XLEN  per-master write data
- mstHWRITE, mstHMASTLOCK  in  MASTERS  each, per-master control
- mstHSIZE, mstHBURST  in  MASTERS x 3  each
- mstHPROT  in  MASTERS x 4
- mstHTRANS  in  MASTERS x 2
- mstHREADY  in  MASTERS  per-master bus HREADY
- can_switch  in  MASTERS  master may release bus next cycle
- mstHRDATA  out  XLEN  read data to all masters
- mstHREADYOUT  out  1  ready to all masters
- mstHRESP  out  1  response to all masters
- master_granted  out  MASTERS  one-hot grant, at most one bit set
- slv_HSEL  out  1
- slv_HADDR  out  PLEN
- slv_HWDATA  out  XLEN
- slv_HWRITE, slv_HMASTLOCK  out  1 each
- slv_HSIZE, slv_HBURST  out  3 each
- slv_HPROT  out  4
- slv_HTRANS  out  2
- slv_HREADY  out  1  bus HREADY to slave
- slv_HRDATA  in  XLEN
- slv_HREADYOUT  in  1
- slv_HRESP  in  1

Function
REQ-003 SHALL hold registers: master_granted (one-hot or zero), dp_owner (one-hot or zero, data-phase owner), rr_last (index of last granted master).
REQ-004 SHALL evaluate a switch permission each cycle: switch_ok = slv_HREADYOUT & (master_granted == 0 | can_switch[granted index]).
REQ-005 SHALL, at a rising edge with switch_ok high, load master_granted with the arbitration winner, or zero when no mstHSEL bit is set.
REQ-006 SHALL pick as winner the requester (mstHSEL set) with the highest mstpriority; ties resolve round-robin, the first tied requester at index above rr_last, wrapping from MASTERS-1 to 0.
REQ-007 SHALL update rr_last to the winner's index on every non-zero grant load; the sole requester is re-granted unchanged.
REQ-008 SHALL hold master_granted unchanged whenever switch_ok is low, regardless of higher-priority requests (no preemption, locked transfers kept).
REQ-009 SHALL drive address-phase outputs combinationally from the granted master: slv_HSEL = mstHSEL[g]; slv_HADDR, slv_HWRITE, slv_HSIZE, slv_HBURST, slv_HPROT, slv_HTRANS, slv_HMASTLOCK = master g's signals.
REQ-010 SHALL, with master_granted zero, drive slv_HSEL=0, slv_HTRANS=IDLE (2'b00), other address outputs 0.
REQ-011 SHALL load dp_owner with master_granted at each rising edge where slv_HREADYOUT is high; hold otherwise.
REQ-012 SHALL drive slv_HWDATA = mstHWDATA[dp_owner] and slv_HREADY = mstHREADY[dp_owner]; with dp_owner zero, slv_HWDATA=0 and slv_HREADY=1.
REQ-013 SHALL drive mstHRDATA = slv_HRDATA, mstHREADYOUT = slv_HREADYOUT, mstHRESP = slv_HRESP combinationally (broadcast; master ports qualify by grant).
REQ-014 SHALL give one-cycle grant latency: request visible at edge N with switch_ok high -> master_granted valid after edge N.
REQ-015 SHALL treat mstpriority values 0..7 unsigned; equal priorities are handled only by REQ-006.

Reset
REQ-016 SHALL, while HRESETn low, asynchronously set master_granted=0, dp_owner=0, rr_last=MASTERS-1; hence slv_HSEL=0, slv_HTRANS=IDLE, slv_HREADY=1.
REQ-017 SHALL, on reset assertion mid-transfer, drop the grant immediately; first grant after release follows REQ-005.

Verification
REQ-018 Single request: master 2 HSEL=1, HTRANS=NONSEQ, addr 0x100, slv_HREADYOUT=1 -> master_granted=5'b00100 next cycle, slv_HADDR=0x100, slv_HSEL=1; dp_owner=master 2 one cycle later.
REQ-019 Priority: masters 0 (prio 1) and 3 (prio 5) request from idle -> master 3 granted; master 0 granted only after can_switch[3]=1 with slv_HREADYOUT=1.
REQ-020 Round-robin: masters 1,2,4 all prio 3, can_switch always 1, continuous requests -> grant sequence 1,2,4,1,2.
REQ-021 Wait states: slv_HREADYOUT=0 for 3 cycles while can_switch[g]=1 and a higher-priority request arrives -> master_granted and dp_owner unchanged for the 3 cycles; switch on first edge with HREADYOUT=1.
REQ-022 Locked burst: granted master with can_switch=0 for INCR4, higher-priority requester waiting -> grant held all 4 beats; slv_HWDATA tracks the original master through the final data phase.
REQ-023 Reset mid-burst: HRESETn pulsed low during a granted transfer -> master_granted=0, slv_HSEL=0, slv_HREADY=1 within the reset-low interval, no clock edge required.
